// File: rtl/jtag_dtm_ext.sv
// JTAG Debug Transport Module, extended edition.
// Lives entirely in the TCK domain. It forwards DMI requests scanned in by the
// TAP to the DMI bus over a valid/ready handshake and returns the captured
// response. It also tracks sticky errors, reported as dtmcs.dmistat, and
// handles dmireset/dmihardreset. A response timeout fails a hung transaction.
module jtag_dtm_ext #(
  parameter int unsigned DMI_ADDR_BITS  = 7,
  parameter int unsigned DMI_DATA_BITS  = 32,
  parameter int unsigned DMI_OP_BITS    = 2,
  parameter int unsigned REQ_BITS       = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS,
  parameter logic [31:0] IDCODE         = 32'h1E200A6F,
  parameter logic [2:0]  IDLE_HINT      = 3'd5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                jtag_tck_i,
  input  logic                jtag_trst_ni,
  // TAP side
  input  logic                tap_req_i,
  input  logic [REQ_BITS-1:0] tap_data_i,
  input  logic                dtmcs_wr_i,
  input  logic [31:0]         dtmcs_wdata_i,
  // DMI request channel
  output logic [REQ_BITS-1:0] dtm_data_o,
  output logic                dtm_valid_o,
  input  logic                dmi_ready_i,
  // DMI response channel
  input  logic [REQ_BITS-1:0] dmi_data_i,
  input  logic                dmi_valid_i,
  output logic                dtm_ready_o,
  // Status presented to the TAP
  output logic [REQ_BITS-1:0] data_o,
  output logic [31:0]         idcode_o,
  output logic [31:0]         dtmcs_o
);

  // A zero timeout still needs a one-bit counter so the declarations stay legal.
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ADDR_LSB = DMI_DATA_BITS + DMI_OP_BITS;

  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_WRITE   = 2'd2;
  localparam logic [1:0] RSP_FAILED = 2'd2;
  localparam logic [1:0] STK_OK     = 2'd0;
  localparam logic [1:0] STK_FAILED = 2'd2;
  localparam logic [1:0] STK_BUSY   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_WAIT = 3'b100
  } state_e;

  state_e              state_q;
  logic [1:0]          sticky_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [REQ_BITS-1:0] req_q;
  logic [REQ_BITS-1:0] resp_q;
  logic [REQ_BITS-1:0] data_q;

  logic       hard_rst;
  logic       soft_rst;
  logic [1:0] sticky_eff;
  logic       op_ok;
  logic       busy;
  logic       timeout_hit;
  logic       cnt_sat;

  assign hard_rst = dtmcs_wr_i & dtmcs_wdata_i[17];
  assign soft_rst = dtmcs_wr_i & dtmcs_wdata_i[16];

  // dmireset takes effect in the same cycle, so a request arriving together
  // with it is judged against the cleared sticky state.
  assign sticky_eff = soft_rst ? STK_OK : sticky_q;

  assign op_ok = (tap_data_i[1:0] == OP_READ) || (tap_data_i[1:0] == OP_WRITE);
  assign busy  = (state_q == ST_REQ) || (state_q == ST_WAIT);

  // The timeout fires on the edge at which the counter would reach the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
  assign cnt_sat     = &cnt_q;

  // Transaction FSM, sticky error tracking, timeout counter and TAP view.
  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      state_q  <= ST_IDLE;
      sticky_q <= STK_OK;
      cnt_q    <= '0;
      req_q    <= '0;
      resp_q   <= '0;
      data_q   <= '0;
    end else begin
      // The TAP view is built from the current registers, which adds one cycle of latency.
      if (state_q != ST_IDLE) begin
        data_q <= {{(REQ_BITS-2){1'b0}}, 2'b11};
      end else if (sticky_q != STK_OK) begin
        data_q <= {resp_q[REQ_BITS-1:2], sticky_q};
      end else begin
        data_q <= resp_q;
      end

      sticky_q <= sticky_eff;

      if (hard_rst) begin
        state_q  <= ST_IDLE;
        sticky_q <= STK_OK;
        cnt_q    <= '0;
        req_q    <= '0;
      end else begin
        // A request while a transaction is in flight is an overrun.
        // NOTE: non-blocking assignments let a later assignment in this block
        // override an earlier one, so a failure in the same cycle takes priority.
        if (busy && tap_req_i && (sticky_eff == STK_OK)) begin
          sticky_q <= STK_BUSY;
        end

        case (state_q)
          ST_IDLE: begin
            if (tap_req_i && (sticky_eff == STK_OK) && op_ok) begin
              req_q   <= tap_data_i;
              cnt_q   <= '0;
              state_q <= ST_REQ;
            end
          end

          ST_REQ: begin
            if (!cnt_sat) cnt_q <= cnt_q + CNT_W'(1);
            if (dmi_ready_i) begin
              state_q <= ST_WAIT;
            end else if (timeout_hit) begin
              state_q <= ST_IDLE;
              resp_q  <= {req_q[REQ_BITS-1:ADDR_LSB], {DMI_DATA_BITS{1'b0}}, RSP_FAILED};
              if (sticky_eff == STK_OK) sticky_q <= STK_FAILED;
            end
          end

          ST_WAIT: begin
            if (!cnt_sat) cnt_q <= cnt_q + CNT_W'(1);
            if (dmi_valid_i) begin
              state_q <= ST_IDLE;
              resp_q  <= dmi_data_i;
              if ((dmi_data_i[1:0] == RSP_FAILED) && (sticky_eff == STK_OK)) begin
                sticky_q <= STK_FAILED;
              end
            end else if (timeout_hit) begin
              state_q <= ST_IDLE;
              resp_q  <= {req_q[REQ_BITS-1:ADDR_LSB], {DMI_DATA_BITS{1'b0}}, RSP_FAILED};
              if (sticky_eff == STK_OK) sticky_q <= STK_FAILED;
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Bits of the DTMCS write word that this block does not act on.
  logic unused_wdata;
  assign unused_wdata = ^{dtmcs_wdata_i[31:18], dtmcs_wdata_i[15:0]};

  assign dtm_valid_o = (state_q == ST_REQ);
  assign dtm_data_o  = req_q;
  assign dtm_ready_o = 1'b1;
  assign data_o      = data_q;
  assign idcode_o    = IDCODE | 32'h1;
  assign dtmcs_o     = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_HINT, sticky_q,
                        6'(DMI_ADDR_BITS), 4'h1};

endmodule

// File: tb/tb_jtag_dtm_ext.sv
// Self-checking bench for jtag_dtm_ext. It runs directed scenarios first,
// then a randomized mix of transactions. Every outcome is checked against a
// transaction-level model that keeps only the sticky code and the last
// response.
module tb_jtag_dtm_ext;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int RW = AW + DW + 2;
  localparam int TO = 8;
  localparam logic [31:0] EXP_IDCODE = 32'h12345679;
  localparam logic [RW-1:0] BUSY_VIEW = RW'(3);

  logic          clk = 1'b0;
  logic          trst_n = 1'b0;
  logic          tap_req = 1'b0;
  logic [RW-1:0] tap_data = '0;
  logic          dtmcs_wr = 1'b0;
  logic [31:0]   dtmcs_wdata = '0;
  logic [RW-1:0] dtm_data;
  logic          dtm_valid;
  logic          dmi_ready = 1'b0;
  logic [RW-1:0] dmi_data = '0;
  logic          dmi_valid = 1'b0;
  logic          dtm_ready;
  logic [RW-1:0] data_o;
  logic [31:0]   idcode;
  logic [31:0]   dtmcs;

  always #5 clk = ~clk;

  jtag_dtm_ext #(
    .IDCODE         (32'h12345678),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .jtag_tck_i    (clk),
    .jtag_trst_ni  (trst_n),
    .tap_req_i     (tap_req),
    .tap_data_i    (tap_data),
    .dtmcs_wr_i    (dtmcs_wr),
    .dtmcs_wdata_i (dtmcs_wdata),
    .dtm_data_o    (dtm_data),
    .dtm_valid_o   (dtm_valid),
    .dmi_ready_i   (dmi_ready),
    .dmi_data_i    (dmi_data),
    .dmi_valid_i   (dmi_valid),
    .dtm_ready_o   (dtm_ready),
    .data_o        (data_o),
    .idcode_o      (idcode),
    .dtmcs_o       (dtmcs)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the sticky error code and the last captured response.
  logic [1:0]    m_sticky = 2'd0;
  logic [RW-1:0] m_resp   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // What the TAP should read back while nothing is in flight.
  function automatic logic [RW-1:0] idle_view();
    if (m_sticky != 2'd0) return {m_resp[RW-1:2], m_sticky};
    return m_resp;
  endfunction

  function automatic logic [31:0] exp_dtmcs(input logic [1:0] st);
    return {14'd0, 3'd0, 3'd5, st, 6'd7, 4'd1};
  endfunction

  function automatic logic [RW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[RW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One TAP request plus the DMI slave behaviour: dr idle cycles before ready,
  // dv idle cycles before the response, an optional overrun pulse in WAIT,
  // and an optional dmireset issued together with the request.
  task automatic do_txn(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [1:0] op, input int dr, input int dv,
                        input logic [DW-1:0] rdata, input logic [1:0] rop,
                        input bit ovr, input bit with_dmirst);
    logic [RW-1:0] req;
    logic [RW-1:0] rsp;
    bit acc;
    req = {addr, wdata, op};
    tap_req  = 1'b1;
    tap_data = req;
    if (with_dmirst) begin
      dtmcs_wr    = 1'b1;
      dtmcs_wdata = 32'h0001_0000;
      m_sticky    = 2'd0;
    end
    acc = (m_sticky == 2'd0) && (op == 2'd1 || op == 2'd2);
    tick();
    tap_req     = 1'b0;
    dtmcs_wr    = 1'b0;
    dtmcs_wdata = '0;
    if (!acc) begin
      check("drop_valid", 64'(dtm_valid), 64'(1'b0));
      tick();
      check("drop_data", 64'(data_o), 64'(idle_view()));
      check("drop_stat", 64'(dtmcs[11:10]), 64'(m_sticky));
      return;
    end
    check("acc_valid", 64'(dtm_valid), 64'(1'b1));
    check("acc_req", 64'(dtm_data), 64'(req));
    for (int i = 0; i < dr; i++) begin
      tick();
      check("req_hold", 64'(dtm_valid), 64'(1'b1));
      check("req_stable", 64'(dtm_data), 64'(req));
    end
    dmi_ready = 1'b1;
    tick();
    dmi_ready = 1'b0;
    check("hs_valid", 64'(dtm_valid), 64'(1'b0));
    check("hs_busy", 64'(data_o), 64'(BUSY_VIEW));
    for (int i = 0; i < dv; i++) begin
      if (ovr && i == 0) begin
        tap_req  = 1'b1;
        tap_data = rand_word();
      end
      tick();
      tap_req = 1'b0;
      if (ovr && i == 0 && m_sticky == 2'd0) m_sticky = 2'd3;
      check("wait_valid", 64'(dtm_valid), 64'(1'b0));
    end
    rsp       = {addr, rdata, rop};
    dmi_valid = 1'b1;
    dmi_data  = rsp;
    tick();
    dmi_valid = 1'b0;
    dmi_data  = rand_word();
    m_resp    = rsp;
    if (rop == 2'd2 && m_sticky == 2'd0) m_sticky = 2'd2;
    check("rsp_busy", 64'(data_o), 64'(BUSY_VIEW));
    tick();
    check("rsp_data", 64'(data_o), 64'(idle_view()));
    check("rsp_stat", 64'(dtmcs[11:10]), 64'(m_sticky));
  endtask

  task automatic do_dmireset();
    dtmcs_wr    = 1'b1;
    dtmcs_wdata = ($urandom() & ~32'h0003_0000) | 32'h0001_0000;
    tick();
    dtmcs_wr    = 1'b0;
    dtmcs_wdata = '0;
    m_sticky    = 2'd0;
    check("dmirst_stat", 64'(dtmcs[11:10]), 64'(2'd0));
    tick();
    check("dmirst_data", 64'(data_o), 64'(idle_view()));
  endtask

  // Ready is held low, so the request must fail after TO cycles in REQ.
  task automatic do_timeout(input logic [AW-1:0] addr);
    if (m_sticky != 2'd0) do_dmireset();
    tap_req  = 1'b1;
    tap_data = {addr, $urandom(), 2'd1};
    tick();
    tap_req = 1'b0;
    check("to_acc", 64'(dtm_valid), 64'(1'b1));
    repeat (TO - 1) tick();
    check("to_pre", 64'(dtm_valid), 64'(1'b1));
    tick();
    check("to_valid", 64'(dtm_valid), 64'(1'b0));
    m_resp   = {addr, 32'd0, 2'b10};
    m_sticky = 2'd2;
    tick();
    check("to_data", 64'(data_o), 64'(idle_view()));
    check("to_stat", 64'(dtmcs[11:10]), 64'(2'd2));
    dmi_valid = 1'b1;
    dmi_data  = rand_word();
    tick();
    dmi_valid = 1'b0;
    tick();
    check("late_data", 64'(data_o), 64'(idle_view()));
    check("late_valid", 64'(dtm_valid), 64'(1'b0));
  endtask

  // dmihardreset while waiting for a response; the late response is dropped.
  task automatic do_hardreset_wait();
    if (m_sticky != 2'd0) do_dmireset();
    tap_req  = 1'b1;
    tap_data = {7'($urandom()), $urandom(), 2'd2};
    tick();
    tap_req   = 1'b0;
    dmi_ready = 1'b1;
    tick();
    dmi_ready = 1'b0;
    check("hr_inwait", 64'(dtm_valid), 64'(1'b0));
    dtmcs_wr    = 1'b1;
    dtmcs_wdata = 32'h0002_0000;
    tick();
    dtmcs_wr    = 1'b0;
    dtmcs_wdata = '0;
    m_sticky    = 2'd0;
    check("hr_req_clr", 64'(dtm_data), 64'(0));
    check("hr_stat", 64'(dtmcs[11:10]), 64'(2'd0));
    dmi_valid = 1'b1;
    dmi_data  = rand_word();
    tick();
    dmi_valid = 1'b0;
    tick();
    check("hr_data", 64'(data_o), 64'(idle_view()));
    check("hr_valid", 64'(dtm_valid), 64'(1'b0));
  endtask

  // dmihardreset together with a legal request in IDLE: the request is dropped.
  task automatic do_hardreset_req();
    tap_req     = 1'b1;
    tap_data    = {7'($urandom()), $urandom(), 2'd1};
    dtmcs_wr    = 1'b1;
    dtmcs_wdata = 32'h0002_0000;
    tick();
    tap_req     = 1'b0;
    dtmcs_wr    = 1'b0;
    dtmcs_wdata = '0;
    m_sticky    = 2'd0;
    check("hrq_valid", 64'(dtm_valid), 64'(1'b0));
    check("hrq_req", 64'(dtm_data), 64'(0));
    tick();
    check("hrq_data", 64'(data_o), 64'(idle_view()));
  endtask

  task automatic do_random_txn();
    int dr;
    int dv;
    bit ovr;
    logic [1:0] rop;
    dr  = int'($urandom_range(0, TO - 2));
    dv  = int'($urandom_range(0, TO - 2 - dr));
    ovr = (dv >= 1) && ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 3))
      0:       rop = 2'd2;
      1:       rop = 2'd3;
      default: rop = 2'd0;
    endcase
    do_txn(7'($urandom()), $urandom(), ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd2,
           dr, dv, $urandom(), rop, ovr, $urandom_range(0, 3) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    check("rst_valid", 64'(dtm_valid), 64'(1'b0));
    check("rst_ready", 64'(dtm_ready), 64'(1'b1));
    check("rst_data", 64'(data_o), 64'(0));
    check("rst_req", 64'(dtm_data), 64'(0));
    check("rst_dtmcs", 64'(dtmcs), 64'(exp_dtmcs(2'd0)));
    check("idcode", 64'(idcode), 64'(EXP_IDCODE));
    #20 trst_n = 1'b1;
    tick();
    check("post_rst_data", 64'(data_o), 64'(0));

    // Read of address 0x10, response two cycles after the handshake.
    do_txn(7'h10, 32'd0, 2'd1, 0, 1, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0);
    check("read10", 64'(data_o), 64'({7'h10, 32'hDEADBEEF, 2'd0}));

    // Fastest path, then the response coinciding with the timeout edge.
    do_txn(7'h21, 32'h55AA55AA, 2'd2, 0, 0, 32'h1, 2'd0, 1'b0, 1'b0);
    do_txn(7'h22, 32'h0, 2'd1, 2, TO - 4, 32'hCAFEF00D, 2'd0, 1'b0, 1'b0);
    check("edge_nofail", 64'(dtmcs[11:10]), 64'(2'd0));

    // Overrun, a third request that must not be forwarded, then recovery.
    do_txn(7'h30, 32'h0, 2'd1, 1, 2, 32'h12345678, 2'd0, 1'b1, 1'b0);
    check("ovr_op", 64'(data_o[1:0]), 64'(2'd3));
    do_txn(7'h31, 32'h0, 2'd1, 0, 0, 32'h0, 2'd0, 1'b0, 1'b0);
    do_dmireset();
    do_txn(7'h32, 32'h0, 2'd1, 0, 0, 32'h0BADF00D, 2'd0, 1'b0, 1'b0);

    // Illegal op while clean is ignored.
    do_txn(7'h33, 32'h0, 2'd0, 0, 0, 32'h0, 2'd0, 1'b0, 1'b0);
    do_txn(7'h34, 32'h0, 2'd3, 0, 0, 32'h0, 2'd0, 1'b0, 1'b0);

    // DMI failure persists across requests until dmireset.
    do_txn(7'h40, 32'h0, 2'd2, 1, 1, 32'h77, 2'd2, 1'b0, 1'b0);
    do_txn(7'h41, 32'h0, 2'd1, 0, 0, 32'h0, 2'd0, 1'b0, 1'b0);
    check("fail_persist", 64'(dtmcs[11:10]), 64'(2'd2));
    // dmireset together with a request: cleared and accepted.
    do_txn(7'h42, 32'h0, 2'd1, 0, 0, 32'h99, 2'd0, 1'b0, 1'b1);

    do_timeout(7'h50);
    do_hardreset_wait();
    do_txn(7'h51, 32'h0, 2'd1, 0, 1, 32'hA5A5A5A5, 2'd0, 1'b0, 1'b0);
    do_hardreset_req();

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: do_random_txn();
        5: do_txn(7'($urandom()), $urandom(), ($urandom_range(0, 1) == 1) ? 2'd0 : 2'd3,
                  0, 0, 32'h0, 2'd0, 1'b0, 1'b0);
        6: do_dmireset();
        7: do_timeout(7'($urandom()));
        8: do_hardreset_wait();
        default: do_hardreset_req();
      endcase
    end

    // Asynchronous reset in the middle of a request.
    if (m_sticky != 2'd0) do_dmireset();
    tap_req  = 1'b1;
    tap_data = {7'h11, 32'h0, 2'd1};
    tick();
    tap_req = 1'b0;
    check("arst_pre", 64'(dtm_valid), 64'(1'b1));
    #2 trst_n = 1'b0;
    #1;
    m_sticky = 2'd0;
    m_resp   = '0;
    check("arst_valid", 64'(dtm_valid), 64'(1'b0));
    check("arst_data", 64'(data_o), 64'(0));
    check("arst_req", 64'(dtm_data), 64'(0));
    check("arst_dtmcs", 64'(dtmcs), 64'(exp_dtmcs(2'd0)));
    check("arst_ready", 64'(dtm_ready), 64'(1'b1));
    #2 trst_n = 1'b1;
    tick();
    do_txn(7'h12, 32'h0, 2'd1, 0, 0, 32'h3C3C3C3C, 2'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
